// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: data-memory req/ack sequencing, stall generation,
// branch resolution and the MEM/WB register. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  input  logic        ZERO_in,
  input  logic [31:0] ALU_OUT_in,
  input  logic [31:0] PC_Branch_in,
  input  logic [31:0] REG_DATA2_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] PC_Branch_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] READ_DATA_out,
  output logic [31:0] ALU_OUT_out,
  output logic [4:0]  rd_out,
  output logic        mem_err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic               regwrite_q, regwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [31:0]        alu_out_q, alu_out_d;
  logic [4:0]         rd_q, rd_d;

  logic               access;
  logic               misaligned;
  logic               timeout;
  logic               retire;
  logic               squash;
  logic [CNT_W-1:0]   wait_cnt_inc;

  assign access = MemRead_in | MemWrite_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = access & (ALU_OUT_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Last permitted WAIT cycle: the MAX_WAIT-th one without an ack.
  assign timeout      = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
  assign wait_cnt_inc = (wait_cnt_q == CNT_W'(MAX_WAIT)) ? wait_cnt_q
                                                         : wait_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    stall      = 1'b0;
    retire     = 1'b0;
    squash     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!access) begin
          retire = 1'b1;
        end else if (misaligned) begin
          retire    = 1'b1;
          squash    = 1'b1;
          mem_err_d = 1'b1;
        end else begin
          stall      = 1'b1;
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout) begin
          retire     = 1'b1;
          squash     = 1'b1;
          mem_err_d  = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = wait_cnt_inc;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stall cycles load a bubble so write-back never sees an instruction twice.
    regwrite_d  = 1'b0;
    memtoreg_d  = 1'b0;
    read_data_d = '0;
    alu_out_d   = '0;
    rd_d        = '0;
    if (retire) begin
      alu_out_d = ALU_OUT_in;
      rd_d      = rd_in;
      if (!squash) begin
        regwrite_d = RegWrite_in;
        memtoreg_d = MemtoReg_in;
        if (state_q == S_WAIT && MemRead_in) begin
          read_data_d = dmem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      read_data_q <= '0;
      alu_out_q   <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
      rd_q        <= rd_d;
    end
  end

  assign dmem_req   = (state_q == S_WAIT);
  assign dmem_we    = dmem_req & MemWrite_in;
  assign dmem_addr  = dmem_req ? ALU_OUT_in   : '0;
  assign dmem_wdata = dmem_req ? REG_DATA2_in : '0;

  assign PCSrc         = Branch_in & ZERO_in & ~stall;
  assign PC_Branch_out = PC_Branch_in;

  assign RegWrite_out  = regwrite_q;
  assign MemtoReg_out  = memtoreg_q;
  assign READ_DATA_out = read_data_q;
  assign ALU_OUT_out   = alu_out_q;
  assign rd_out        = rd_q;
  assign mem_err       = mem_err_q;

endmodule
